// File: rtl/enigma_pkg.sv
// Shared Enigma constants: rotor wirings (III, II, I), notches, reflector B, FSM states
// and modulo-26 helpers used by the stream core and its rotor stage.
package enigma_pkg;

  localparam int ALPHA = 26;

  typedef logic [25:0][4:0] wiring_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FWD,
    ST_REFL,
    ST_BWD,
    ST_DONE
  } state_t;

  // Wirings are written as letter strings; the first letter is the image of A.
  function automatic wiring_t wiring_from_text(input logic [8*26-1:0] txt);
    wiring_t w;
    for (int i = 0; i < 26; i++) begin
      w[i] = 5'(txt[8*(25-i) +: 8] - 8'd65);
    end
    return w;
  endfunction

  function automatic wiring_t invert_wiring(input wiring_t w);
    wiring_t r;
    r = '0;
    for (int i = 0; i < 26; i++) begin
      r[w[i]] = 5'(i);
    end
    return r;
  endfunction

  localparam wiring_t FWD_TBL_0 = wiring_from_text("BDFHJLCPRTXVZNYEIWGAKMUSQO");
  localparam wiring_t FWD_TBL_1 = wiring_from_text("AJDKSIRUXBLHWTMCQGZNPYFVOE");
  localparam wiring_t FWD_TBL_2 = wiring_from_text("EKMFLGDQVZNTOWYHXUSPAIBRCJ");
  localparam wiring_t REV_TBL_0 = invert_wiring(FWD_TBL_0);
  localparam wiring_t REV_TBL_1 = invert_wiring(FWD_TBL_1);
  localparam wiring_t REV_TBL_2 = invert_wiring(FWD_TBL_2);
  localparam wiring_t REFL_B    = wiring_from_text("YRUHQSLDPXNGOKMIEBFZCWVJAT");

  function automatic logic [1:0] tbl_of(input int k);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < k; i++) begin
      r = (r == 2'd2) ? 2'd0 : r + 2'd1;
    end
    return r;
  endfunction

  function automatic logic [4:0] notch_of(input logic [1:0] tbl);
    case (tbl)
      2'd0:    return 5'd21;
      2'd1:    return 5'd4;
      default: return 5'd16;
    endcase
  endfunction

  function automatic logic [4:0] mod26_add(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 6'd26) s = s - 6'd26;
    return s[4:0];
  endfunction

  function automatic logic [4:0] mod26_sub(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] s;
    s = {1'b0, a} - {1'b0, b};
    if (a < b) s = s + 6'd26;
    return s[4:0];
  endfunction

endpackage

// File: rtl/enigma_rotor_stage.sv
// One rotor pass: offset the character by the rotor position, look up the forward or
// reverse wiring, then remove the offset again.
module enigma_rotor_stage
  import enigma_pkg::*;
(
  input  logic [4:0] ch,
  input  logic [4:0] pos,
  input  logic [1:0] tbl,
  input  logic       dir,
  output logic [4:0] ch_out
);

  logic [4:0] idx;
  logic [4:0] wired;

  assign idx = mod26_add(ch, pos);

  always_comb begin
    wired = '0;
    case ({dir, tbl})
      3'b000:  wired = FWD_TBL_0[idx];
      3'b001:  wired = FWD_TBL_1[idx];
      3'b010:  wired = FWD_TBL_2[idx];
      3'b100:  wired = REV_TBL_0[idx];
      3'b101:  wired = REV_TBL_1[idx];
      3'b110:  wired = REV_TBL_2[idx];
      default: wired = '0;
    endcase
  end

  assign ch_out = mod26_sub(wired, pos);

endmodule

// File: rtl/enigma_stream_core.sv
// Sequential Enigma core: steps the rotors on accept, then walks one rotor stage per cycle
// forward, through reflector B and back, presenting the result on a valid/ready port.
module enigma_stream_core
  import enigma_pkg::*;
#(
  parameter int NUM_ROTORS = 3,
  parameter int CW         = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_load,
  input  logic [NUM_ROTORS*CW-1:0] cfg_pos,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CW-1:0]            in_char,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CW-1:0]            out_char,
  output logic [NUM_ROTORS*CW-1:0] pos_out
);

  localparam int KW = (NUM_ROTORS > 1) ? $clog2(NUM_ROTORS) : 1;

  state_t              state;
  logic [KW-1:0]       k_cnt;
  logic [CW-1:0]       c;
  logic                bypass;
  logic [4:0]          pos_q    [NUM_ROTORS];
  logic [4:0]          pos_next [NUM_ROTORS];
  logic [4:0]          pos_cfg  [NUM_ROTORS];
  logic [1:0]          rotor_tbl[NUM_ROTORS];
  logic [NUM_ROTORS-2:0] at_notch;
  logic [NUM_ROTORS-1:0] step;
  logic [4:0]          stage_out;
  logic                accept;
  logic                char_ok;

  assign in_ready = (state == ST_IDLE) & ~cfg_load;
  assign accept   = in_valid & in_ready;
  assign char_ok  = in_char < CW'(ALPHA);

  // Per-rotor wiring selection, odometer carry with double step, and config sanitising.
  for (genvar g = 0; g < NUM_ROTORS; g++) begin : g_rotor
    localparam logic [1:0] T = tbl_of(g);
    logic [CW-1:0] field;
    assign field        = cfg_pos[g*CW +: CW];
    assign rotor_tbl[g] = T;
    if (g < NUM_ROTORS - 1) begin : g_notch
      assign at_notch[g] = (pos_q[g] == notch_of(T));
    end
    if (g == 0) begin : g_fast
      assign step[g] = 1'b1;
    end else if (g <= NUM_ROTORS - 2) begin : g_mid
      assign step[g] = at_notch[g-1] | at_notch[g];
    end else begin : g_slow
      assign step[g] = at_notch[g-1];
    end
    assign pos_next[g]          = step[g] ? mod26_add(pos_q[g], 5'd1) : pos_q[g];
    assign pos_cfg[g]           = (field < CW'(ALPHA)) ? 5'(field) : 5'd0;
    assign pos_out[g*CW +: CW]  = CW'(pos_q[g]);
  end

  enigma_rotor_stage u_stage (
    .ch     (5'(c)),
    .pos    (pos_q[k_cnt]),
    .tbl    (rotor_tbl[k_cnt]),
    .dir    (state == ST_BWD),
    .ch_out (stage_out)
  );

  // DONE spends its first cycle raising out_valid, so results appear 2N+2 edges after accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      k_cnt     <= '0;
      c         <= '0;
      bypass    <= 1'b0;
      out_valid <= 1'b0;
      out_char  <= '0;
      for (int k = 0; k < NUM_ROTORS; k++) pos_q[k] <= 5'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cfg_load) begin
            for (int k = 0; k < NUM_ROTORS; k++) pos_q[k] <= pos_cfg[k];
          end else if (accept) begin
            c      <= in_char;
            bypass <= ~char_ok;
            k_cnt  <= '0;
            state  <= ST_FWD;
            if (char_ok) begin
              for (int k = 0; k < NUM_ROTORS; k++) pos_q[k] <= pos_next[k];
            end
          end
        end
        ST_FWD: begin
          if (!bypass) c <= CW'(stage_out);
          if (k_cnt == KW'(NUM_ROTORS - 1)) state <= ST_REFL;
          else k_cnt <= k_cnt + 1'b1;
        end
        ST_REFL: begin
          if (!bypass) c <= CW'(REFL_B[5'(c)]);
          k_cnt <= KW'(NUM_ROTORS - 1);
          state <= ST_BWD;
        end
        ST_BWD: begin
          if (!bypass) c <= CW'(stage_out);
          if (k_cnt == '0) begin
            out_char <= bypass ? c : CW'(stage_out);
            state    <= ST_DONE;
          end else begin
            k_cnt <= k_cnt - 1'b1;
          end
        end
        ST_DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_enigma_stream_core.sv
// Scoreboard bench for enigma_stream_core with 3- and 4-rotor instances: stimulus pushes
// expectations, per-instance monitors pop and compare whenever a result is handed over.
module tb_enigma_stream_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        out_ready;
  logic [4:0]  in_char;

  logic        cfg_load3, in_valid3, in_ready3, out_valid3;
  logic [14:0] cfg_pos3, pos_out3;
  logic [4:0]  out_char3;

  logic        cfg_load4, in_valid4, in_ready4, out_valid4;
  logic [19:0] cfg_pos4, pos_out4;
  logic [4:0]  out_char4;

  enigma_stream_core #(.NUM_ROTORS(3), .CW(5)) dut3 (
    .clk(clk), .rst(rst), .cfg_load(cfg_load3), .cfg_pos(cfg_pos3),
    .in_valid(in_valid3), .in_ready(in_ready3), .in_char(in_char),
    .out_valid(out_valid3), .out_ready(out_ready), .out_char(out_char3),
    .pos_out(pos_out3)
  );

  enigma_stream_core #(.NUM_ROTORS(4), .CW(5)) dut4 (
    .clk(clk), .rst(rst), .cfg_load(cfg_load4), .cfg_pos(cfg_pos4),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_char(in_char),
    .out_valid(out_valid4), .out_ready(out_ready), .out_char(out_char4),
    .pos_out(pos_out4)
  );

  // mode: 0 = positions only, 1 = exact character, 2 = character must differ from input
  typedef struct {
    logic [4:0]  in_c;
    logic [4:0]  exp_c;
    int          mode;
    logic [19:0] exp_pos;
  } exp_t;

  exp_t       sb3[$];
  exp_t       sb4[$];
  logic [4:0] cap3[$];
  int         n_vec  = 0;
  int         n_fail = 0;

  logic [4:0] t1_exp [5] = '{5'd1, 5'd3, 5'd25, 5'd6, 5'd14};
  logic [4:0] hello  [5] = '{5'd7, 5'd4, 5'd11, 5'd11, 5'd14};
  logic [4:0] ct     [5];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic checkDiffers(input string name, input logic [4:0] act, input logic [4:0] forbidden);
    n_vec++;
    if (act === forbidden) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, required anything but %0d", name, act, forbidden);
    end
  endtask

  task automatic reportTimeout(input string name);
    n_vec++;
    n_fail++;
    $display("[TB] FAIL %s: wait expired, required DUT response", name);
  endtask

  always @(negedge clk) begin : mon3
    exp_t e;
    if (!rst && out_valid3 && out_ready) begin
      cap3.push_back(out_char3);
      if (sb3.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("[TB] FAIL unexpected_out3: got char %0d, required no output", out_char3);
      end else begin
        e = sb3.pop_front();
        if (e.mode == 1) checkOutput("char3", 32'(out_char3), 32'(e.exp_c));
        else if (e.mode == 2) checkDiffers("char3_ne_in", out_char3, e.in_c);
        checkOutput("pos3", 32'(pos_out3), 32'(e.exp_pos));
      end
    end
  end

  always @(negedge clk) begin : mon4
    exp_t e;
    if (!rst && out_valid4 && out_ready) begin
      if (sb4.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("[TB] FAIL unexpected_out4: got char %0d, required no output", out_char4);
      end else begin
        e = sb4.pop_front();
        if (e.mode == 1) checkOutput("char4", 32'(out_char4), 32'(e.exp_c));
        else if (e.mode == 2) checkDiffers("char4_ne_in", out_char4, e.in_c);
        checkOutput("pos4", 32'(pos_out4), 32'(e.exp_pos));
      end
    end
  end

  // Issue one character; mode -1 sends it without expecting any output.
  task automatic applyStimulus(input int sel, input logic [4:0] ch, input int mode,
                               input logic [4:0] exp_c, input logic [19:0] exp_pos);
    exp_t e;
    int   t;
    t = 0;
    while (!((sel == 3) ? in_ready3 : in_ready4) && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 200) begin
      reportTimeout("in_ready");
      return;
    end
    e.in_c    = ch;
    e.exp_c   = exp_c;
    e.mode    = mode;
    e.exp_pos = exp_pos;
    if (mode >= 0) begin
      if (sel == 3) sb3.push_back(e);
      else sb4.push_back(e);
    end
    in_char = ch;
    if (sel == 3) in_valid3 = 1'b1;
    else in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid3 = 1'b0;
    in_valid4 = 1'b0;
  endtask

  task automatic waitDrain(input int sel);
    int t;
    t = 0;
    while (((sel == 3) ? sb3.size() : sb4.size()) != 0 && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 500) reportTimeout("drain");
  endtask

  task automatic loadPos(input int sel, input logic [19:0] p);
    if (sel == 3) begin
      cfg_pos3  = p[14:0];
      cfg_load3 = 1'b1;
    end else begin
      cfg_pos4  = p;
      cfg_load4 = 1'b1;
    end
    @(posedge clk); #1;
    cfg_load3 = 1'b0;
    cfg_load4 = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int t;
    rst = 1'b1; out_ready = 1'b1; in_char = '0;
    cfg_load3 = 1'b0; in_valid3 = 1'b0; cfg_pos3 = '0;
    cfg_load4 = 1'b0; in_valid4 = 1'b0; cfg_pos4 = '0;
    doReset();

    checkOutput("rst_out_valid", 32'(out_valid3), 32'd0);
    checkOutput("rst_out_char",  32'(out_char3),  32'd0);
    checkOutput("rst_pos",       32'(pos_out3),   32'd0);
    checkOutput("rst_in_ready",  32'(in_ready3),  32'd1);

    $display("[TB] AAAAA from AAA");
    for (int i = 0; i < 5; i++) applyStimulus(3, 5'd0, 1, t1_exp[i], 20'(i + 1));
    waitDrain(3);

    $display("[TB] double step");
    loadPos(3, 20'({5'd0, 5'd3, 5'd20}));
    applyStimulus(3, 5'd0, 2, 5'd0, 20'({5'd0, 5'd3, 5'd21}));
    applyStimulus(3, 5'd0, 2, 5'd0, 20'({5'd0, 5'd4, 5'd22}));
    applyStimulus(3, 5'd0, 2, 5'd0, 20'({5'd1, 5'd5, 5'd23}));
    waitDrain(3);

    $display("[TB] reciprocity");
    loadPos(3, 20'd0);
    cap3.delete();
    for (int i = 0; i < 5; i++) applyStimulus(3, hello[i], 2, 5'd0, 20'(i + 1));
    waitDrain(3);
    checkOutput("cipher_count", 32'(cap3.size()), 32'd5);
    for (int i = 0; i < 5; i++) ct[i] = (i < cap3.size()) ? cap3[i] : 5'd0;
    loadPos(3, 20'd0);
    for (int i = 0; i < 5; i++) applyStimulus(3, ct[i], 1, hello[i], 20'(i + 1));
    waitDrain(3);

    $display("[TB] backpressure");
    loadPos(3, 20'd0);
    out_ready = 1'b0;
    applyStimulus(3, 5'd0, 1, 5'd1, 20'd1);
    t = 0;
    while (!out_valid3 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) reportTimeout("out_valid");
    for (int i = 0; i < 20; i++) begin
      checkOutput("hold_valid",    32'(out_valid3), 32'd1);
      checkOutput("hold_char",     32'(out_char3),  32'd1);
      checkOutput("hold_in_ready", 32'(in_ready3),  32'd0);
      checkOutput("hold_pos",      32'(pos_out3),   32'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("release_idle", 32'(in_ready3), 32'd1);
    waitDrain(3);

    $display("[TB] wrap and invalid");
    loadPos(3, 20'd25);
    applyStimulus(3, 5'd0, 2, 5'd0, 20'd0);
    applyStimulus(3, 5'd28, 1, 5'd28, 20'd0);
    waitDrain(3);
    loadPos(3, 20'({5'd30, 5'd2, 5'd30}));
    checkOutput("cfg_clamp", 32'(pos_out3), 32'({5'd0, 5'd2, 5'd0}));

    $display("[TB] reset in BWD");
    loadPos(3, 20'd0);
    applyStimulus(3, 5'd0, -1, 5'd0, 20'd0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("abort_valid", 32'(out_valid3), 32'd0);
    checkOutput("abort_pos",   32'(pos_out3),   32'd0);
    repeat (15) @(posedge clk);
    #1 checkOutput("abort_no_out", 32'(out_valid3), 32'd0);

    $display("[TB] cfg_load during FWD");
    applyStimulus(3, 5'd0, 1, 5'd1, 20'd1);
    cfg_pos3  = 15'({5'd5, 5'd5, 5'd5});
    cfg_load3 = 1'b1;
    @(posedge clk); #1;
    cfg_load3 = 1'b0;
    waitDrain(3);
    checkOutput("cfg_ignored", 32'(pos_out3), 32'd1);

    $display("[TB] four rotors");
    doReset();
    checkOutput("rst_pos4", 32'(pos_out4), 32'd0);
    for (int i = 0; i < 5; i++) applyStimulus(4, 5'd0, 2, 5'd0, 20'(i + 1));
    waitDrain(4);
    loadPos(4, {5'd0, 5'd0, 5'd3, 5'd20});
    applyStimulus(4, 5'd0, 2, 5'd0, {5'd0, 5'd0, 5'd3, 5'd21});
    applyStimulus(4, 5'd0, 2, 5'd0, {5'd0, 5'd0, 5'd4, 5'd22});
    applyStimulus(4, 5'd0, 2, 5'd0, {5'd0, 5'd1, 5'd5, 5'd23});
    waitDrain(4);

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
